hc595_rx_monitor: RTL and testbench
===================================

# hc595_rx_monitor

Receive-side model of the 74HC595 serial display link. It samples the SRCLK/RCLK/SER lines produced by the HC595 driver in the 7-segment counter design, rebuilds each latched N-bit frame, and checks its bit count. Optionally, it decodes every common-anode 7-segment byte back to BCD. It is used as a loopback checker on the board and as the scoreboard front-end in the display testbenches.

## Interface
Parameters:
- N, 32, frame width in bits; multiple of 8, ≥ 8; N/8 digits per frame.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- SRCLK  input  1  shift clock from the link; asynchronous to clk.
- RCLK  input  1  latch clock from the link; asynchronous to clk.
- SER  input  1  serial data from the link, MSB of the frame first.
- data_out  output  N  last latched frame.
- frame_valid  output  1  one-cycle pulse; data_out and frame_err updated.
- frame_err  output  1  last latched frame did not contain exactly N shifts.
- dig_bcd  output  4*(N/8)  decoded digits; present only with the decode feature.
- seg_err  output  N/8  per-digit "not a valid 0-9 pattern" flag; present only with the decode feature.

## Operation
- Synchronizer:
  - SRCLK, RCLK and SER each pass through a 2-flop synchronizer, followed by one history flop.
  - A rise is detected as sync = 1 and history = 0.
  - SER is taken from the same synchronizer stage as SRCLK, so data and clock stay aligned.
- Shift: on an SRCLK rise, shreg <= {shreg[N-2:0], SER_sync}. After N shifts, shreg equals the transmitted word, and the first bit sent ends up at bit N-1.
- Bit counter:
  - Counts SRCLK rises since the last latch.
  - Width $clog2(N)+2; saturates at all-ones with no wrap.
- Latch: on an RCLK rise:
  - data_out <= shreg;
  - frame_err <= (bit_cnt != N);
  - frame_valid <= 1 for one cycle;
  - bit_cnt <= 0.
- Simultaneous SRCLK and RCLK rise in the same clk cycle:
  - The latch takes the pre-shift shreg and checks the pre-shift count.
  - The new bit is shifted in, and bit_cnt becomes 1.
  - This matches the real 595 behaviour with tied clocks.
- RCLK rise with zero preceding shifts: data_out reloads the unchanged shreg; frame_err = 1.
- shreg is never cleared except by reset, so partial frames carry over into the next frame.
- Reset: all synchronizer and history flops, shreg, bit_cnt, data_out, frame_valid, frame_err, dig_bcd and seg_err go to 0. Reset asserted mid-frame discards the partial frame. No frame_valid pulse is generated by reset release.

## Timing
- Definition: edge 0 is the first clk rising edge that samples a pin at 1.
- The rise is detected on edge 2, and the effect is registered on edge 2.
  - data_out, frame_err and frame_valid change on edge 2.
  - frame_valid stays high exactly one cycle (edge 2 to edge 3).
- Decoded outputs (dig_bcd, seg_err) are registered from data_out one cycle later: they update on edge 3.
- Input requirements:
  - SRCLK high and low phases each ≥ 3 clk periods.
  - SER stable ≥ 3 clk periods before the SRCLK rise.
  - RCLK high ≥ 3 clk periods.
  - The first SRCLK rise after an RCLK rise comes ≥ 3 clk periods later, unless tied-clock behaviour is intended.
- Throughput: one bit per ≥ 6 clk cycles; no back-pressure.

## Configuration
- Macro: HC595_RX_SEGDECODE_EN.
- Defined — dig_bcd and seg_err ports exist:
  - Byte k = data_out[N-1-8k -: 8] is decoded to dig_bcd[4k+3:4k].
  - The byte layout is {dp,g,f,e,d,c,b,a}, active low. Bit 7 (dp) is ignored.
  - Lower-7-bit patterns: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Any other pattern gives digit 4'hF and seg_err[k] = 1.
- Undefined: no decode logic and no dig_bcd/seg_err ports. The block provides raw frames only.

## Test plan
- Reset:
  - Stimulus: assert rst mid-frame after 13 shifts, release it, then send a full frame.
  - Required: all outputs 0 during reset; the frame latches with frame_err = 0.
- Nominal frame:
  - Stimulus: shift 32'h99B0A4F9 MSB first, then pulse RCLK.
  - Required: one frame_valid pulse on edge 2, data_out = 32'h99B0A4F9, frame_err = 0.
  - With the macro: dig_bcd = 16'h1234 (digit 0 = 4 at bits 3:0 … digit 3 = 1), seg_err = 0.
- Short and long frames:
  - Stimulus: 31 shifts then latch; next 40 shifts then latch.
  - Required: frame_err = 1 both times; the second data_out holds the last 32 bits sent.
- Tied clocks:
  - Stimulus: SRCLK and RCLK rise together on the 33rd edge.
  - Required: data_out = the first 32 bits; the next frame's count starts at 1.
- Invalid segment:
  - Stimulus: frame 32'hC0FFC0C0.
  - Required: dig_bcd = 16'h00F0, seg_err = 4'b0010.
- Latch with no shifts:
  - Stimulus: two RCLK pulses back to back.
  - Required: the second latch gives the same data_out with frame_err = 1.

Source files
------------

// File: rtl/hc595_rx_monitor_if.sv
// Link bundle for the 74HC595 serial display link: shift clock, latch clock
// and serial data. The driver side owns the master modport; the receive
// monitor uses the slave modport.
interface hc595_rx_monitor_if;
   logic SRCLK;
   logic RCLK;
   logic SER;

   modport master (output SRCLK, output RCLK, output SER);
   modport slave  (input  SRCLK, input  RCLK, input  SER);
endinterface

// File: rtl/hc595_rx_monitor.sv
// Receive-side monitor for the 74HC595 display link.
// It synchronises SRCLK/RCLK/SER into clk, rebuilds each latched N-bit frame
// and flags frames that did not contain exactly N shifts.
// Optional feature macro HC595_RX_SEGDECODE_EN adds dig_bcd/seg_err, which
// decode each common-anode 7-segment byte of data_out back to BCD one cycle
// after the frame is latched.
module hc595_rx_monitor #(
   parameter int N = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   hc595_rx_monitor_if.slave    link,
   output logic [N-1:0]         data_out,
   output logic                 frame_valid,
   output logic                 frame_err
`ifdef HC595_RX_SEGDECODE_EN
   ,
   output logic [4*(N/8)-1:0]   dig_bcd,
   output logic [N/8-1:0]       seg_err
`endif
);

   localparam int CW = $clog2(N) + 2;
   localparam int ND = N / 8;

   logic          srclk_meta_q, srclk_meta_d;
   logic          srclk_sync_q, srclk_sync_d;
   logic          srclk_hist_q, srclk_hist_d;
   logic          rclk_meta_q,  rclk_meta_d;
   logic          rclk_sync_q,  rclk_sync_d;
   logic          rclk_hist_q,  rclk_hist_d;
   logic          ser_meta_q,   ser_meta_d;
   logic          ser_sync_q,   ser_sync_d;

   logic [N-1:0]  shreg_q,       shreg_d;
   logic [CW-1:0] bit_cnt_q,     bit_cnt_d;
   logic [N-1:0]  data_out_q,    data_out_d;
   logic          frame_valid_q, frame_valid_d;
   logic          frame_err_q,   frame_err_d;

   logic          srclk_rise;
   logic          rclk_rise;

   // Two-flop synchronisers plus history flops for edge detection. SER is
   // taken from the same stage as SRCLK so data stays aligned with its clock.
   always_comb begin
      srclk_meta_d = link.SRCLK;
      srclk_sync_d = srclk_meta_q;
      srclk_hist_d = srclk_sync_q;
      rclk_meta_d  = link.RCLK;
      rclk_sync_d  = rclk_meta_q;
      rclk_hist_d  = rclk_sync_q;
      ser_meta_d   = link.SER;
      ser_sync_d   = ser_meta_q;
      srclk_rise   = srclk_sync_q & ~srclk_hist_q;
      rclk_rise    = rclk_sync_q & ~rclk_hist_q;
   end

   // Shift, count and latch. A latch always sees the pre-shift register and
   // count, so tied SRCLK/RCLK behaves like the real part: the coincident bit
   // belongs to the next frame and starts its count at 1.
   always_comb begin
      shreg_d       = shreg_q;
      bit_cnt_d     = bit_cnt_q;
      data_out_d    = data_out_q;
      frame_err_d   = frame_err_q;
      frame_valid_d = 1'b0;

      if (srclk_rise) begin
         shreg_d = {shreg_q[N-2:0], ser_sync_q};
      end

      if (rclk_rise) begin
         data_out_d    = shreg_q;
         frame_err_d   = (bit_cnt_q != CW'(N));
         frame_valid_d = 1'b1;
         bit_cnt_d     = srclk_rise ? CW'(1) : '0;
      end else if (srclk_rise && (bit_cnt_q != '1)) begin
         bit_cnt_d = bit_cnt_q + CW'(1);
      end
   end

   // State registers for synchronisers, shifter and latched frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         srclk_meta_q  <= 1'b0;
         srclk_sync_q  <= 1'b0;
         srclk_hist_q  <= 1'b0;
         rclk_meta_q   <= 1'b0;
         rclk_sync_q   <= 1'b0;
         rclk_hist_q   <= 1'b0;
         ser_meta_q    <= 1'b0;
         ser_sync_q    <= 1'b0;
         shreg_q       <= '0;
         bit_cnt_q     <= '0;
         data_out_q    <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         srclk_meta_q  <= srclk_meta_d;
         srclk_sync_q  <= srclk_sync_d;
         srclk_hist_q  <= srclk_hist_d;
         rclk_meta_q   <= rclk_meta_d;
         rclk_sync_q   <= rclk_sync_d;
         rclk_hist_q   <= rclk_hist_d;
         ser_meta_q    <= ser_meta_d;
         ser_sync_q    <= ser_sync_d;
         shreg_q       <= shreg_d;
         bit_cnt_q     <= bit_cnt_d;
         data_out_q    <= data_out_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign data_out    = data_out_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;

`ifdef HC595_RX_SEGDECODE_EN
   logic [4*ND-1:0] dig_bcd_q, dig_bcd_d;
   logic [ND-1:0]   seg_err_q, seg_err_d;

   // Decode each active-low {dp,g,f,e,d,c,b,a} byte; dp is ignored and any
   // non-digit pattern yields 4'hF with its error flag set.
   always_comb begin
      logic [6:0] seg_v;
      dig_bcd_d = '0;
      seg_err_d = '0;
      seg_v     = '0;
      for (int k = 0; k < ND; k++) begin
         seg_v = data_out_q[N-2-8*k -: 7];
         case (seg_v)
            7'h40:   dig_bcd_d[4*k +: 4] = 4'd0;
            7'h79:   dig_bcd_d[4*k +: 4] = 4'd1;
            7'h24:   dig_bcd_d[4*k +: 4] = 4'd2;
            7'h30:   dig_bcd_d[4*k +: 4] = 4'd3;
            7'h19:   dig_bcd_d[4*k +: 4] = 4'd4;
            7'h12:   dig_bcd_d[4*k +: 4] = 4'd5;
            7'h02:   dig_bcd_d[4*k +: 4] = 4'd6;
            7'h78:   dig_bcd_d[4*k +: 4] = 4'd7;
            7'h00:   dig_bcd_d[4*k +: 4] = 4'd8;
            7'h10:   dig_bcd_d[4*k +: 4] = 4'd9;
            default: begin
               dig_bcd_d[4*k +: 4] = 4'hF;
               seg_err_d[k]        = 1'b1;
            end
         endcase
      end
   end

   // Decoded digits trail data_out by one clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dig_bcd_q <= '0;
         seg_err_q <= '0;
      end else begin
         dig_bcd_q <= dig_bcd_d;
         seg_err_q <= seg_err_d;
      end
   end

   assign dig_bcd = dig_bcd_q;
   assign seg_err = seg_err_q;
`endif

endmodule

// File: tb/tb_hc595_rx_monitor.sv
// Directed bench for hc595_rx_monitor (N = 32): nominal, reset mid-frame,
// short/long, tied-clock, invalid-segment and empty-latch frames.
module tb_hc595_rx_monitor;

   logic        clk;
   logic        rst;
   logic [31:0] data_out;
   logic        frame_valid;
   logic        frame_err;
`ifdef HC595_RX_SEGDECODE_EN
   logic [15:0] dig_bcd;
   logic [3:0]  seg_err;
`endif

   int n_vec   = 0;
   int n_miss  = 0;
   int n_pulse = 0;

   hc595_rx_monitor_if link_if ();

   hc595_rx_monitor #(.N(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .link        (link_if.slave),
      .data_out    (data_out),
      .frame_valid (frame_valid),
      .frame_err   (frame_err)
`ifdef HC595_RX_SEGDECODE_EN
      ,
      .dig_bcd     (dig_bcd),
      .seg_err     (seg_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (frame_valid) n_pulse++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic shift_bit(input logic b);
      @(negedge clk) link_if.SER = b;
      repeat (3) @(negedge clk);
      link_if.SRCLK = 1'b1;
      repeat (3) @(negedge clk);
      link_if.SRCLK = 1'b0;
   endtask

   task automatic shift_bits(input logic [31:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
   endtask

   // RCLK pulse (optionally with a coincident SRCLK rise carrying bit b);
   // checks frame_valid is low after edges 0/1, high after edge 2, low after 3.
   task automatic latch(input string tag, input bit tied, input logic b);
      int p0;
      p0 = n_pulse;
      if (tied) begin
         @(negedge clk) link_if.SER = b;
         repeat (3) @(negedge clk);
         link_if.SRCLK = 1'b1;
      end else begin
         @(negedge clk);
      end
      link_if.RCLK = 1'b1;
      @(negedge clk) chk({tag, ".fv_e0"}, frame_valid, 1'b0);
      @(negedge clk) chk({tag, ".fv_e1"}, frame_valid, 1'b0);
      @(negedge clk) chk({tag, ".fv_e2"}, frame_valid, 1'b1);
      @(negedge clk) chk({tag, ".fv_e3"}, frame_valid, 1'b0);
      link_if.RCLK  = 1'b0;
      link_if.SRCLK = 1'b0;
      repeat (4) @(negedge clk);
      chk({tag, ".npulse"}, n_pulse - p0, 1);
   endtask

   task automatic chk_frame(input string tag, input logic [31:0] d, input logic e);
      chk({tag, ".data"}, data_out, d);
      chk({tag, ".err"}, frame_err, e);
   endtask

   initial begin
      int p0;
      rst = 1'b1;
      link_if.SRCLK = 1'b0;
      link_if.RCLK  = 1'b0;
      link_if.SER   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst0.data", data_out, 32'h0);
      chk("rst0.fv", frame_valid, 1'b0);
      chk("rst0.err", frame_err, 1'b0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // nominal frame
      shift_bits(32'h99B0A4F9, 32);
      latch("nom", 1'b0, 1'b0);
      chk_frame("nom", 32'h99B0A4F9, 1'b0);
`ifdef HC595_RX_SEGDECODE_EN
      chk("nom.bcd", dig_bcd, 16'h1234);
      chk("nom.segerr", seg_err, 4'b0000);
`endif

      // reset mid-frame after 13 shifts
      shift_bits(32'hFFFFFFFF, 13);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      chk("rstm.data", data_out, 32'h0);
      chk("rstm.fv", frame_valid, 1'b0);
      chk("rstm.err", frame_err, 1'b0);
`ifdef HC595_RX_SEGDECODE_EN
      chk("rstm.bcd", dig_bcd, 16'h0);
      chk("rstm.segerr", seg_err, 4'b0000);
`endif
      repeat (2) @(negedge clk);
      p0 = n_pulse;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("rstm.nopulse", n_pulse - p0, 0);
      shift_bits(32'h12345678, 32);
      latch("post_rst", 1'b0, 1'b0);
      chk_frame("post_rst", 32'h12345678, 1'b0);

      // short frame: top 31 bits of 2468ACE1 behind previous 12345678
      shift_bits(32'h2468ACE1 >> 1, 31);
      latch("short", 1'b0, 1'b0);
      chk_frame("short", 32'h12345670, 1'b1);

      // long frame: 40 shifts, last 32 are DEADBEEF
      shift_bits(32'h000000A5, 8);
      shift_bits(32'hDEADBEEF, 32);
      latch("long", 1'b0, 1'b0);
      chk_frame("long", 32'hDEADBEEF, 1'b1);

      // tied clocks: 33rd bit coincides with the latch
      shift_bits(32'hCAFEF00D, 32);
      latch("tied", 1'b1, 1'b1);
      chk_frame("tied", 32'hCAFEF00D, 1'b0);
      shift_bits(32'h0BADF00D, 31);
      latch("tied_next", 1'b0, 1'b0);
      chk_frame("tied_next", 32'h8BADF00D, 1'b0);

      // invalid segment in digit 1
      shift_bits(32'hC0FFC0C0, 32);
      latch("inval", 1'b0, 1'b0);
      chk_frame("inval", 32'hC0FFC0C0, 1'b0);
`ifdef HC595_RX_SEGDECODE_EN
      chk("inval.bcd", dig_bcd, 16'h00F0);
      chk("inval.segerr", seg_err, 4'b0010);
`endif

      // latch with no shifts
      latch("empty", 1'b0, 1'b0);
      chk_frame("empty", 32'hC0FFC0C0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
